sysbus_arbiter: RTL
===================

SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the width of the data/address field.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the width of the tag field.
REQ-003 Parameter BEATS, default 8, SHALL set the number of data beats per transaction.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 mN_reqcyc, N=0/1  in  1  SHALL indicate a request from requester N (0 = instruction fetch, 1 = data).
REQ-007 mN_req  in  BUS_DATA_WIDTH  SHALL carry the requester address or write data.
REQ-008 mN_reqtag  in  BUS_TAG_WIDTH  SHALL carry the requester tag; bit 12 = 1 means write and 0 means read.
REQ-009 mN_reqack  out  1  SHALL be the request acknowledge returned to requester N.
REQ-010 mN_respcyc  out  1  SHALL be the response-valid signal to requester N.
REQ-011 mN_resp / mN_resptag  out  BUS_DATA_WIDTH / BUS_TAG_WIDTH  SHALL carry the response data and tag to requester N.
REQ-012 mN_respack  in  1  SHALL be the response acknowledge from requester N.
REQ-013 bus_reqcyc, bus_req, bus_reqtag, bus_respack  out  SHALL form the shared bus master side, using the widths above.
REQ-014 bus_reqack, bus_respcyc, bus_resp, bus_resptag  in  SHALL form the shared bus response side.
REQ-015 owner  out  2  SHALL report the current owner: 2'b00 none, 2'b01 m0, 2'b10 m1.

Function
REQ-016 The FSM SHALL have four states: IDLE, ADDR, WDATA and RDATA.
REQ-017 IDLE: on a clock edge with any mN_reqcyc set, the FSM SHALL latch the winner into owner and go to ADDR, giving one cycle of arbitration latency.
REQ-018 Winner selection SHALL be round-robin: a lone requester wins, and on a tie the requester indicated by priority pointer prio (reset value 0) wins.
REQ-019 In ADDR, bus_reqcyc, bus_req and bus_reqtag SHALL combinationally equal the owner's inputs, and the other requester SHALL see reqack=0.
REQ-020 mN_reqack SHALL equal bus_reqack for the owner only, and SHALL be 0 for the non-owner in every state.
REQ-021 ADDR exit on bus_reqack & bus_reqcyc: the FSM SHALL go to WDATA if the latched tag bit 12 = 1, otherwise to RDATA, with beat counter cnt cleared to 0.
REQ-022 WDATA: each cycle with owner reqcyc & bus_reqack SHALL count one beat, and the beat at cnt == BEATS-1 SHALL end the transaction.
REQ-023 RDATA: bus_respcyc SHALL route to the owner's mN_respcyc only, and bus_respack SHALL equal the owner's mN_respack.
REQ-024 In RDATA, each cycle with bus_respcyc & bus_respack SHALL count one beat, and the beat at cnt == BEATS-1 SHALL end the transaction.
REQ-025 mN_resp and mN_resptag SHALL be driven with bus_resp and bus_resptag to both requesters at all times; validity SHALL be qualified only by mN_respcyc.
REQ-026 cnt SHALL be $clog2(BEATS) bits wide and SHALL never wrap within a transaction.
REQ-027 Transaction end SHALL move the FSM to IDLE, set owner to 00, and set prio to the non-owner.
REQ-028 Arbitration for the next transaction SHALL occur on the cycle after end; bus_reqcyc SHALL be 0 in IDLE.
REQ-029 A non-owner request arriving mid-transaction SHALL wait, with no acknowledge, until the next IDLE arbitration.
REQ-030 Owner reqcyc dropping in ADDR SHALL abandon the request: the FSM SHALL return to IDLE next cycle with prio unchanged.
REQ-031 bus_respcyc asserted in IDLE, ADDR or WDATA SHALL be ignored, with bus_respack=0 and both mN_respcyc=0.

Reset
REQ-032 reset low SHALL immediately, at any time and mid-transaction, force: state IDLE, owner 00, prio 0, cnt 0.
REQ-033 While reset is low, all outputs SHALL be 0: bus_reqcyc, bus_respack, mN_reqack and mN_respcyc.
REQ-034 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-035 m0 read of addr 0x1000, bus acks, then 8 resp beats 0x1..0x8 -> m0_respcyc set for exactly 8 beats, m1_respcyc=0, owner returns to 00.
REQ-036 m0 and m1 request in the same cycle after reset -> m0 is served first, then m1 is granted one cycle after m0's 8th beat.
REQ-037 m1 holds reqcyc continuously while m0 issues back-to-back reads -> grants alternate m0, m1, m0, and neither requester is starved.
REQ-038 m1 write (tag[12]=1) with 8 data beats 0xA0..0xA7 -> bus_req carries the same values, and the FSM is in IDLE the cycle after the 8th ack.
REQ-039 reset pulled low at read beat 4 -> outputs are 0 immediately, and a new m1 request after release is granted with cnt=0.
REQ-040 Stray bus_respcyc in IDLE -> bus_respack=0 and both mN_respcyc=0.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-requester round-robin arbiter for a shared burst bus (instruction fetch vs data).
// One transaction at a time: address phase, then BEATS write-data or read-response beats.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic [1:0]                owner
);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam int              WR_BIT    = 12;
    localparam logic [1:0]      OWN_NONE  = 2'b00;
    localparam logic [1:0]      OWN_M0    = 2'b01;
    localparam logic [1:0]      OWN_M1    = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_tag;
    logic                      own_respack;
    logic                      beat_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner-side view of the requester ports; nothing is selected while owner is none.
    always_comb begin
        own_reqcyc  = (owner_q == OWN_M1) ? m1_reqcyc  : ((owner_q == OWN_M0) & m0_reqcyc);
        own_req     = (owner_q == OWN_M1) ? m1_req     : m0_req;
        own_tag     = (owner_q == OWN_M1) ? m1_reqtag  : m0_reqtag;
        own_respack = (owner_q == OWN_M1) ? m1_respack : ((owner_q == OWN_M0) & m0_respack);
    end

    always_comb begin
        bus_reqcyc  = ((state_q == ADDR) || (state_q == WDATA)) & own_reqcyc;
        bus_req     = own_req;
        bus_reqtag  = own_tag;
        bus_respack = (state_q == RDATA) & own_respack;
        m0_reqack   = (owner_q == OWN_M0) & bus_reqack;
        m1_reqack   = (owner_q == OWN_M1) & bus_reqack;
        m0_respcyc  = (state_q == RDATA) & (owner_q == OWN_M0) & bus_respcyc;
        m1_respcyc  = (state_q == RDATA) & (owner_q == OWN_M1) & bus_respcyc;
        m0_resp     = bus_resp;
        m0_resptag  = bus_resptag;
        m1_resp     = bus_resp;
        m1_resptag  = bus_resptag;
        owner       = owner_q;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        beat_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_reqcyc || m1_reqcyc) begin
                    state_d = ADDR;
                    if (m0_reqcyc && m1_reqcyc) begin
                        owner_d = prio_q ? OWN_M1 : OWN_M0;
                    end else begin
                        owner_d = m1_reqcyc ? OWN_M1 : OWN_M0;
                    end
                end
            end
            ADDR: begin
                if (!own_reqcyc) begin
                    // Abandoned request: give up ownership without touching the pointer.
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end else if (bus_reqack) begin
                    state_d = own_tag[WR_BIT] ? WDATA : RDATA;
                    cnt_d   = '0;
                end
            end
            WDATA:   beat_done = own_reqcyc & bus_reqack;
            RDATA:   beat_done = bus_respcyc & own_respack;
            default: state_d = IDLE;
        endcase
        if (beat_done) begin
            if (cnt_q == LAST_BEAT) begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                prio_d  = (owner_q == OWN_M0);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule
